sample_window_shifter: RTL

//  Upstream stage of majority_func. Samples a serial 1-bit line once every
//  DIV enabled clocks and shifts each sample into a SIZE-bit window.

---
 rtl/sample_window_shifter.sv | 101 ++++++++++
 1 files changed

// File: rtl/sample_window_shifter.sv
// sample_window_shifter: divided-rate serial sampler feeding a SIZE-bit
// window, with fill tracking and a strided fresh-window pulse.
module sample_window_shifter #(
  parameter int SIZE   = 9,
  parameter int DIV    = 4,
  parameter int STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            din,
  input  logic            clear,
  output logic [SIZE-1:0] data,
  output logic            data_valid,
  output logic [3:0]      fill_count,
  output logic            full
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]    SZ       = 4'(SIZE);
  localparam logic [3:0]    SZ_LAST  = 4'(SIZE - 1);
  localparam logic [3:0]    ST_LAST  = 4'(STRIDE - 1);

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] div_cnt;
  logic [3:0]    stride_cnt;
  logic [3:0]    stride_n;
  logic [3:0]    fill_n;
  logic          valid_n;
  logic          tick;

  assign tick   = en && (div_cnt == DIV_LAST);
  assign fill_n = (fill_count == SZ) ? SZ : fill_count + 4'd1;

  // Next-state, stride and fresh-window decision, evaluated only on ticks
  always_comb begin
    state_n  = state;
    stride_n = stride_cnt;
    valid_n  = 1'b0;
    if (tick) begin
      unique case (state)
        FILL: begin
          if (fill_count == SZ_LAST) begin
            valid_n  = 1'b1;
            stride_n = 4'd0;
            state_n  = RUN;
          end
        end
        RUN: begin
          if (stride_cnt == ST_LAST) begin
            valid_n  = 1'b1;
            stride_n = 4'd0;
          end else begin
            stride_n = stride_cnt + 4'd1;
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  // Control registers; a flush returns the FSM to FILL with no pulse
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= FILL;
      stride_cnt <= 4'd0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_n;
      stride_cnt <= stride_n;
      data_valid <= valid_n;
    end
  end

  // Divider, window shift and fill tracking; a tick during clear is dropped
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt    <= '0;
      data       <= '0;
      fill_count <= 4'd0;
      full       <= 1'b0;
    end else begin
      if (en) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
      if (tick) begin
        data       <= {data[SIZE-2:0], din};
        fill_count <= fill_n;
        full       <= (fill_n == SZ);
      end
    end
  end

endmodule
